// File: rtl/pipeline_hazard_controller.sv
// Hazard detection, stall/flush sequencing and EX forwarding selects for a 5-stage MIPS pipeline.
// Optional stall-cycle counter is built only when HAZARD_STATS_EN is defined.
module pipeline_hazard_controller #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned REG_AW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_muldiv,
    input  logic              id_hilo_read,
    input  logic              ex_load_instr,
    input  logic              ex_rf_enable,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_rf_enable,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_rf_enable,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_branch_taken,
    output logic              pc_ld,
    output logic              npc_ld,
    output logic              if_ld,
    output logic              S,
    output logic              if_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              muldiv_busy,
    output logic [15:0]       stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        MULDIV = 2'b01
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pending_flush_q, pending_flush_d;

    logic busy_int;
    logic load_use;
    logic hilo_haz;
    logic stall;
    logic issue_muldiv;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              ex_en,
        input logic              ex_ld,
        input logic [REG_AW-1:0] ex_d,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_d,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_d
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (ex_en && !ex_ld && ex_d == src)
                sel = 2'b01;
            else if (mem_en && mem_d == src)
                sel = 2'b10;
            else if (wb_en && wb_d == src)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        busy_int = (state_q == MULDIV);
        load_use = ex_load_instr && ex_rf_enable && (ex_rd != '0) &&
                   ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        hilo_haz = busy_int && (cnt_q != 4'd0) && (id_hilo_read || id_muldiv);
        stall    = load_use || hilo_haz;
        issue_muldiv = id_muldiv && !stall;
    end

    // Next-state logic; a mult/div may only issue when cnt has reached zero.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pending_flush_d = stall ? (pending_flush_q || ex_branch_taken) : 1'b0;
        case (state_q)
            RUN: begin
                if (issue_muldiv) begin
                    state_d = MULDIV;
                    cnt_d   = CNT_LOAD;
                end
            end
            MULDIV: begin
                if (cnt_q == 4'd0) begin
                    if (issue_muldiv) begin
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= RUN;
            cnt_q           <= 4'd0;
            pending_flush_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    // Outputs are held in a safe bubble state while reset is asserted.
    always_comb begin
        pc_ld       = 1'b0;
        npc_ld      = 1'b0;
        if_ld       = 1'b0;
        S           = 1'b1;
        if_flush    = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        muldiv_busy = 1'b0;
        if (reset) begin
            pc_ld       = !stall;
            npc_ld      = !stall;
            if_ld       = !stall;
            S           = stall;
            if_flush    = (ex_branch_taken || pending_flush_q) && !stall;
            fwd_a       = fwd_sel(id_rs, ex_rf_enable, ex_load_instr, ex_rd,
                                  mem_rf_enable, mem_rd, wb_rf_enable, wb_rd);
            fwd_b       = fwd_sel(id_rt, ex_rf_enable, ex_load_instr, ex_rd,
                                  mem_rf_enable, mem_rd, wb_rf_enable, wb_rd);
            muldiv_busy = busy_int;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            stall_count_q <= 16'd0;
        else
            stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central sequencing block for the five-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Detects load-use and HI/LO (mult/div) hazards and tracks a multi-cycle mult/div busy window.
- Drives the load enables for PC, nPC and the IF pipeline register, the S (NOP-select) input of the ID control mux, and the IF flush on taken branches.
- Generates the EX operand forwarding selects.

Parameters:
MULDIV_LAT, 4, cycles the HI/LO unit stays busy after a mult/div issues from ID (legal range 1..15).
REG_AW, 5, register-address width.

Ports:
clk  input  1  pipeline clock; all state updates on its rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk.
id_rs  input  REG_AW  rs field of the instruction in ID.
id_rt  input  REG_AW  rt field of the instruction in ID.
id_uses_rs  input  1  ID instruction reads rs.
id_uses_rt  input  1  ID instruction reads rt.
id_muldiv  input  1  ID instruction is mult/multu/div/divu.
id_hilo_read  input  1  ID instruction is mfhi/mflo.
ex_load_instr  input  1  EX-stage load flag.
ex_rf_enable  input  1  EX-stage register-file write enable.
ex_rd  input  REG_AW  EX-stage destination register.
mem_rf_enable  input  1  MEM-stage register-file write enable.
mem_rd  input  REG_AW  MEM-stage destination register.
wb_rf_enable  input  1  WB-stage register-file write enable.
wb_rd  input  REG_AW  WB-stage destination register.
ex_branch_taken  input  1  branch/jump resolved taken in EX.
pc_ld  output  1  PC register load enable.
npc_ld  output  1  nPC register load enable.
if_ld  output  1  IF/ID pipeline register load enable.
S  output  1  ID mux select; 1 inserts NOP control signals.
if_flush  output  1  clears the IF/ID register on the next edge.
fwd_a  output  2  rs operand select: 00 RF, 01 EX, 10 MEM, 11 WB.
fwd_b  output  2  rt operand select, same encoding as fwd_a.
muldiv_busy  output  1  HI/LO unit busy.
stall_count  output  16  stall-cycle counter (optional feature).

Behaviour:
Reset (reset=0 at an edge):
- state=RUN, cnt=0, pending_flush=0.
- While reset is low, outputs are: pc_ld=npc_ld=if_ld=0, S=1, if_flush=0, fwd_a=fwd_b=00, muldiv_busy=0.

State machine (2-bit state; cnt is a 4-bit down-counter):
- RUN (00) → MULDIV (01) when id_muldiv=1 and stall=0; cnt loads MULDIV_LAT-1.
- MULDIV: muldiv_busy=1; cnt decrements each cycle.
  - At cnt=0 → RUN, unless an unstalled id_muldiv issues that same cycle; then cnt reloads and state stays MULDIV.
- MULDIV_LAT=1 gives exactly one busy cycle.

Hazard terms (combinational from the current cycle's inputs):
- load_use = ex_load_instr & ex_rf_enable & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- hilo_haz = muldiv_busy & cnt≠0 & (id_hilo_read | id_muldiv).
- stall = load_use | hilo_haz.

Outputs:
- stall=1: pc_ld=npc_ld=if_ld=0, S=1 in the same cycle. Load-use costs exactly one bubble.
- stall=0: pc_ld=npc_ld=if_ld=1, S=0.

Flush:
- if_flush = (ex_branch_taken | pending_flush) & ~stall.
- If ex_branch_taken and stall coincide, pending_flush sets and the flush is issued on the first non-stall cycle; pending_flush then clears.
- The delay-slot instruction already in ID is never squashed.

Forwarding, per operand:
- Priority: EX (ex_rf_enable & ~ex_load_instr & ex_rd==src & src≠0) > MEM (mem_rf_enable & mem_rd==src & src≠0) > WB (wb_rf_enable & wb_rd==src & src≠0) > RF.
- Register 0 is never forwarded.

Reset mid-operation clears the MULDIV state, cnt and pending_flush at the next edge.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_count increments on every cycle with stall=1, saturates at 16'hFFFF, and clears on reset.
- Undefined: stall_count is constant 0 and no counter logic is built.

Test Plan:
- Load-use: EX lw rd=5 (ex_load_instr=1, ex_rf_enable=1); ID add with rs=5 → one cycle of S=1 and pc_ld=npc_ld=if_ld=0; next cycle, with the load in MEM (mem_rd=5), S=0 and fwd_a=10.
- Forwarding priority: ex_rd=mem_rd=wb_rd=7, all rf_enable=1, id_rt=7 → fwd_b=01; repeat with ex_rf_enable=0 → 10; repeat with rt=0 → 00.
- Mult/div busy with MULDIV_LAT=4: mult issues from ID; mflo in ID next cycle → stalled 3 cycles, released when cnt=0; muldiv_busy high 4 cycles, then state=RUN.
- Branch during stall: ex_branch_taken=1 in the same cycle as load_use → if_flush=0 that cycle, if_flush=1 the next cycle, pending_flush=0 after.
- Reset mid-MULDIV: reset=0 with cnt=2 → next edge state=RUN, muldiv_busy=0, S=1 while reset is held low.
- HAZARD_STATS_EN: 3 load-use stalls plus 3 hilo stalls → stall_count=6; reset → 0.
